// File: rtl/store_trace_pkg.sv
// Shared constants, FSM state type and frame byte selection for the store trace UART.
package store_trace_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 9;
  localparam int unsigned ENTRY_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Byte 0 is the sync marker; bytes 1..8 walk the {dataadr, writedata} entry MSB first.
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                            input logic [3:0]         idx);
    logic [7:0] b;
    b = SYNC_BYTE;
    for (int unsigned i = 1; i < FRAME_BYTES; i++) begin
      if (idx == 4'(i)) b = entry[ENTRY_W - 8*i +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/store_trace_uart_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_uart.sv
// Captures every core store into a FIFO and streams it as a 9-byte 8N1 UART frame.
module store_trace_uart
  import store_trace_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   baud_cnt;
  logic               bit_done;
  logic [2:0]         bit_idx;
  logic [3:0]         byte_idx;
  logic [ENTRY_W-1:0] frame;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty;
  logic               pop;
  logic [7:0]         cur_byte;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (memwrite),
    .pop   (pop),
    .din   ({dataadr, writedata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign cur_byte = frame_byte(frame, byte_idx);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_done) state_next = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_done) state_next = (byte_idx == 4'(FRAME_BYTES - 1)) ? IDLE : START;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  // The baud counter restarts on every bit boundary and every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      overflow <= 1'b0;
    end else begin
      if (bit_done || state_next != state) baud_cnt <= '0;
      else if (state != IDLE)              baud_cnt <= baud_cnt + 1'b1;

      if (pop) begin
        frame    <= fifo_dout;
        byte_idx <= '0;
      end

      if (state == START && bit_done) bit_idx <= '0;
      if (state == DATA  && bit_done) bit_idx <= bit_idx + 1'b1;
      if (state == STOP  && bit_done && state_next == START) byte_idx <= byte_idx + 1'b1;

      if (memwrite && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_store_trace_uart.sv
// Directed bench: decodes tx into bytes and checks frames, timing and FIFO flags.
module tb_store_trace_uart;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        memwrite  = 1'b0;
  logic [31:0] dataadr   = '0;
  logic [31:0] writedata = '0;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  int         mon_st;
  logic [7:0] mon_by;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [71:0] frame;
  } vec_t;
  vec_t vecs[5];

  store_trace_uart #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  // UART receiver: samples the middle of each 10-cycle bit.
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      mon_st = cyc;
      repeat (5) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (10) @(negedge clk);
        mon_by[b] = tx;
      end
      repeat (10) @(negedge clk);
      rx_bytes.push_back(mon_by);
      rx_start.push_back(mon_st);
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int t = 0;
    while (rx_bytes.size() < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, rx_bytes.size(), target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, busy, 0);
  endtask

  function automatic logic [71:0] frame_at(input int b);
    logic [71:0] f = '0;
    for (int i = 0; i < 9; i++) f = {f[63:0], rx_bytes[b + i]};
    return f;
  endfunction

  initial begin
    int base;
    int n0;
    int bc;

    vecs[0] = '{32'h0000_0054, 32'h0000_0007, 72'hA5_0000_0054_0000_0007};
    vecs[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 72'hA5_0000_0010_DEAD_BEEF};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 72'hA5_1234_5678_9ABC_DEF0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 72'hA5_FFFF_FFFF_0000_0000};
    vecs[4] = '{32'h8000_0001, 32'h5A5A_5A5A, 72'hA5_8000_0001_5A5A_5A5A};

    // Held in reset while the core strobes stores: nothing may be captured.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      memwrite  = i[0];
      dataadr   = i;
      writedata = ~i;
      #1 check("reset_outputs", {tx, busy, fifo_full, overflow}, 4'b1000);
    end
    memwrite = 1'b0;
    reset    = 1'b1;
    base = rx_bytes.size();
    bc   = busy_cnt;
    tick(100);
    check("reset_nothing_sent", rx_bytes.size() - base, 0);
    check("reset_no_busy", busy_cnt - bc, 0);
    check("reset_flags", {fifo_full, overflow}, 2'b00);

    // Single stores from the vector table: frame bytes, latency, busy length.
    for (int v = 0; v < 5; v++) begin
      base = rx_bytes.size();
      bc   = busy_cnt;
      n0   = cyc;
      memwrite  = 1'b1;
      dataadr   = vecs[v].adr;
      writedata = vecs[v].dat;
      tick(1);
      memwrite = 1'b0;
      wait_bytes(base + 9, 1200, $sformatf("vec%0d_bytes", v));
      wait_idle(50, $sformatf("vec%0d_idle", v));
      tick(3);
      check($sformatf("vec%0d_frame", v), frame_at(base), vecs[v].frame);
      check($sformatf("vec%0d_latency", v), rx_start[base] - n0, 2);
      check($sformatf("vec%0d_busy_len", v), busy_cnt - bc, 900);
    end

    // Ten back-to-back stores: nine survive, the tenth overflows.
    do_reset();
    base = rx_bytes.size();
    for (int i = 0; i < 10; i++) begin
      memwrite  = 1'b1;
      dataadr   = 32'h100 + i;
      writedata = i;
      tick(1);
      if (i == 8) check("burst_full_before_drop", {fifo_full, overflow}, 2'b10);
    end
    memwrite = 1'b0;
    check("burst_overflow", {fifo_full, overflow}, 2'b11);
    wait_bytes(base + 81, 9 * 901 + 300, "burst_bytes");
    wait_idle(50, "burst_idle");
    tick(1200);
    check("burst_no_extra", rx_bytes.size() - base, 81);
    for (int f = 0; f < 9; f++)
      check($sformatf("burst_frame%0d", f), frame_at(base + 9*f), {8'hA5, 32'h100 + f, 32'(f)});
    check("burst_sticky", {fifo_full, overflow}, 2'b01);

    // Full FIFO with a store landing on the pop edge.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      memwrite  = 1'b1;
      dataadr   = 32'h300 + i;
      writedata = 32'hC000_0000 + i;
      tick(1);
    end
    memwrite = 1'b0;
    check("full_queued", {fifo_full, overflow}, 2'b10);
    wait_idle(1000, "full_first_done");
    base = rx_bytes.size();
    memwrite  = 1'b1;
    dataadr   = 32'h3FF;
    writedata = 32'hC0DE_0009;
    tick(1);
    memwrite = 1'b0;
    check("pop_push_flags", {busy, fifo_full, overflow}, 3'b110);
    wait_bytes(base + 81, 9 * 901 + 300, "pop_push_bytes");
    for (int f = 0; f < 8; f++)
      check($sformatf("pop_push_frame%0d", f), frame_at(base + 9*f),
            {8'hA5, 32'h301 + f, 32'hC000_0001 + f});
    check("pop_push_last", frame_at(base + 72), 72'hA5_0000_03FF_C0DE_0009);
    check("pop_push_no_ovf", overflow, 0);

    // Reset in the middle of byte 3 with four entries still queued.
    do_reset();
    base = rx_bytes.size();
    for (int i = 0; i < 5; i++) begin
      memwrite  = 1'b1;
      dataadr   = 32'h200 + i;
      writedata = 32'h1111_0000 + i;
      tick(1);
    end
    memwrite = 1'b0;
    wait_bytes(base + 3, 400, "midreset_progress");
    tick(20);
    reset = 1'b0;
    #1 check("midreset_immediate", {tx, busy, fifo_full}, 3'b100);
    tick(3);
    reset = 1'b1;
    tick(300);
    base = rx_bytes.size();
    bc   = busy_cnt;
    tick(1500);
    check("midreset_silent", rx_bytes.size() - base, 0);
    check("midreset_no_busy", busy_cnt - bc, 0);
    memwrite  = 1'b1;
    dataadr   = 32'h0000_0ABC;
    writedata = 32'h0102_0304;
    tick(1);
    memwrite = 1'b0;
    wait_bytes(base + 9, 1200, "midreset_new_bytes");
    tick(1500);
    check("midreset_only_new", rx_bytes.size() - base, 9);
    check("midreset_new_frame", frame_at(base), 72'hA5_0000_0ABC_0102_0304);

    // Three identical stores: frames separated by exactly one idle cycle.
    do_reset();
    base = rx_bytes.size();
    n0   = cyc;
    for (int i = 0; i < 3; i++) begin
      memwrite  = 1'b1;
      dataadr   = 32'h10;
      writedata = 32'hDEAD_BEEF;
      tick(1);
    end
    memwrite = 1'b0;
    wait_bytes(base + 27, 3000, "triple_bytes");
    for (int f = 0; f < 3; f++)
      check($sformatf("triple_frame%0d", f), frame_at(base + 9*f), 72'hA5_0000_0010_DEAD_BEEF);
    check("triple_latency", rx_start[base] - n0, 2);
    check("triple_byte_spacing", rx_start[base + 1] - rx_start[base], 100);
    check("triple_gap01", rx_start[base + 9] - rx_start[base], 901);
    check("triple_gap12", rx_start[base + 18] - rx_start[base + 9], 901);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
